sequence_show_module: RTL and testbench

- Game stage directly downstream of the idle stage.
- Started by the idle stage's start/done pulse together with the latched mode, level and speed.
- Builds the Simon colour sequence from a 16-bit LFSR and stores it in an internal 32-entry buffer.
- Plays the first N entries on the four colour LEDs with speed-dependent timing, then hands off to the player-check stage, which reads the buffer back through a random-access port.

---
 rtl/sequence_show_module.sv | 143 ++++++++++++++
 tb/tb_sequence_show_module.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_show_module.sv
// Simon sequence builder/player: appends an LFSR colour each round, then plays the
// sequence on one-hot LEDs. Define SEQ_NO_REPEAT_EN to forbid consecutive repeats.
module sequence_show_module #(
    parameter int unsigned TICK_DIV  = 12_500_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned MAX_LEN   = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_start,
    input  logic       i_next,
    input  logic [1:0] i_mode,
    input  logic [1:0] i_level,
    input  logic [1:0] i_speed,
    input  logic [4:0] i_rd_idx,
    output logic [1:0] o_rd_color,
    output logic [5:0] o_len,
    output logic [3:0] o_led,
    output logic       o_active,
    output logic       o_done,
    output logic       o_complete
);

    localparam int unsigned CW = $clog2(4 * TICK_DIV + 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, APPEND, ON, OFF} state_t;

    state_t        state, next_state;
    logic [15:0]   lfsr;
    logic [5:0]    len;
    logic [5:0]    target;
    logic [1:0]    speed;
    logic [4:0]    play_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] on_last;
    logic [1:0]    buffer [MAX_LEN];
    logic [1:0]    new_color;
    logic          restart, clear, advance, set_done, set_complete;

    assign on_last    = CW'((4 - int'(speed)) * TICK_DIV - 1);
    assign o_rd_color = buffer[i_rd_idx];
    assign o_len      = len;
    assign o_active   = (state != IDLE);

    always_comb begin
        new_color = lfsr[1:0];
`ifdef SEQ_NO_REPEAT_EN
        if (len != '0 && lfsr[1:0] == buffer[5'(len - 6'd1)])
            new_color = lfsr[1:0] + 2'd1;
`endif
    end

    always_comb begin
        o_led = '0;
        if (state == ON)
            o_led[buffer[play_idx]] = 1'b1;
    end

    // Enable has highest priority, then a (re)start, then per-state behaviour.
    always_comb begin
        next_state   = state;
        restart      = 1'b0;
        clear        = 1'b0;
        advance      = 1'b0;
        set_done     = 1'b0;
        set_complete = 1'b0;
        if (!i_enable) begin
            next_state = IDLE;
            clear      = 1'b1;
        end else if (i_start) begin
            next_state = APPEND;
            restart    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_next && len != '0) begin
                        if (len == target) set_complete = 1'b1;
                        else               next_state   = APPEND;
                    end
                end
                APPEND: next_state = ON;
                ON: begin
                    if (cnt == on_last) next_state = OFF;
                end
                OFF: begin
                    if (cnt == OFF_LAST) begin
                        if (({1'b0, play_idx} + 6'd1) < len) begin
                            next_state = ON;
                            advance    = 1'b1;
                        end else begin
                            next_state = IDLE;
                            set_done   = 1'b1;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            len        <= '0;
            target     <= '0;
            speed      <= '0;
            play_idx   <= '0;
            cnt        <= '0;
            o_done     <= 1'b0;
            o_complete <= 1'b0;
        end else begin
            state      <= next_state;
            lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (restart && i_mode == 2'b01)
                lfsr <= LFSR_SEED;
            cnt        <= (next_state == state && !restart) ? cnt + 1'b1 : '0;
            o_done     <= set_done;
            o_complete <= set_complete;
            if (state == APPEND) begin
                len      <= len + 6'd1;
                play_idx <= '0;
            end
            if (advance)
                play_idx <= play_idx + 5'd1;
            if (restart) begin
                target <= {1'b0, i_level, 3'b000} + 6'd8;
                speed  <= i_speed;
                len    <= '0;
            end
            if (clear)
                len <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == APPEND)
            buffer[len[4:0]] <= new_color;
    end

endmodule

// File: tb/tb_sequence_show_module.sv
// Scoreboard bench for sequence_show_module: stimulus queues expected LED/done/complete
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_sequence_show_module;

    localparam int unsigned TICK = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int K_LED = 0, K_DONE = 1, K_COMPLETE = 2;

    logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b1, start = 1'b0, next = 1'b0;
    logic [1:0] mode = '0, level = '0, speed = '0;
    logic [4:0] rd_idx = '0;
    logic [1:0] rd_color;
    logic [5:0] len_o;
    logic [3:0] led;
    logic       active, done, complete;

    sequence_show_module #(
        .TICK_DIV (TICK),
        .LFSR_SEED(SEED),
        .MAX_LEN  (32)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_enable  (enable),
        .i_start   (start),
        .i_next    (next),
        .i_mode    (mode),
        .i_level   (level),
        .i_speed   (speed),
        .i_rd_idx  (rd_idx),
        .o_rd_color(rd_color),
        .o_len     (len_o),
        .o_led     (led),
        .o_active  (active),
        .o_done    (done),
        .o_complete(complete)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [3:0] led;
        int         dur;
        int         gap;
    } ev_t;

    ev_t        q[$];
    ev_t        e;
    int         n_checks = 0, n_pass = 0;
    int         cyc = 0, done_seen = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_led = '0;
    int         on_cnt = 0, zero_cnt = 0, cur_dur = 0;
    int         e0 = 0, on_dur = 0, mlen = 0, d0 = 0;
    logic [1:0] mc [32];
    logic [1:0] tmp_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail(input string nm);
        n_checks++;
        $display("FAIL %s: expected event did not occur (t=%0t)", nm, $time);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] lfsr_after(input int steps);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < steps; i++) s = galois(s);
        return s;
    endfunction

    // Monitor: LED rising edge, done and complete pulses each consume one queued event.
    always @(negedge clk) begin
        if (done) done_seen++;
        if (led != '0) begin
            if (prev_led == '0) begin
                if (mon_en) begin
                    if (q.size() == 0) fail("unexpected_led");
                    else begin
                        e = q.pop_front();
                        chk("ev_kind_led", e.kind, K_LED);
                        chk("led_value", led, e.led);
                        if (e.gap >= 0) chk("off_gap", zero_cnt, e.gap);
                        cur_dur = e.dur;
                    end
                end
                on_cnt = 1;
            end else on_cnt++;
        end else begin
            if (prev_led != '0) begin
                if (mon_en) chk("on_time", on_cnt, cur_dur);
                zero_cnt = 1;
            end else zero_cnt++;
        end
        if (mon_en && done) begin
            if (q.size() == 0) fail("unexpected_done");
            else begin
                e = q.pop_front();
                chk("ev_kind_done", e.kind, K_DONE);
                chk("done_gap", zero_cnt, e.gap);
            end
        end
        if (mon_en && complete) begin
            if (q.size() == 0) fail("unexpected_complete");
            else begin
                e = q.pop_front();
                chk("ev_kind_complete", e.kind, K_COMPLETE);
            end
        end
        prev_led = led;
    end

    // APPEND runs in the cycle after sampling edge e; the LFSR has then stepped (e - e0) times.
    task automatic model_append(input int ed);
        logic [15:0] s;
        logic [1:0]  c;
        s = lfsr_after(ed - e0);
        c = s[1:0];
`ifdef SEQ_NO_REPEAT_EN
        if (mlen > 0 && c == mc[mlen-1]) c = c + 2'd1;
`endif
        mc[mlen] = c;
        mlen++;
        for (int i = 0; i < mlen; i++)
            q.push_back('{K_LED, 4'(4'b0001 << mc[i]), on_dur, (i == 0) ? -1 : int'(TICK)});
        // o_done is registered, so it lands one cycle after the last OFF cycle
        q.push_back('{K_DONE, 4'b0000, 0, int'(TICK) + 1});
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [1:0] l, input logic [1:0] s);
        @(posedge clk); #1;
        mode = m; level = l; speed = s; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        e0     = cyc;
        q.delete();
        mon_en = 1'b1;
        mlen   = 0;
        on_dur = (4 - int'(s)) * int'(TICK);
        chk("len_cleared", len_o, 0);
        model_append(e0);
        @(posedge clk); #1;
        chk("len_after_start", len_o, 1);
    endtask

    task automatic raw_next();
        @(posedge clk); #1; next = 1'b1;
        @(posedge clk); #1; next = 1'b0;
    endtask

    task automatic pulse_next();
        raw_next();
        model_append(cyc);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            fail(nm);
            q.delete();
        end
    endtask

    task automatic wait_led(input bit on, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if ((led != '0) == on) hit = 1'b1;
        end
        if (!hit) fail(nm);
    endtask

    task automatic check_rd(input string nm);
        for (int i = 0; i < mlen; i++) begin
            rd_idx = 5'(i);
            #1;
            chk(nm, rd_color, mc[i]);
        end
    endtask

    initial begin
        #12;
        chk("rst_len", len_o, 0);
        chk("rst_led", led, 0);
        chk("rst_active", active, 0);
        chk("rst_done", done, 0);
        chk("rst_complete", complete, 0);
        @(negedge clk); rst_n = 1'b1;

        // Fixed-seed game twice: first colour is SEED[1:0] = 1 -> LED 4'b0010
        pulse_start(2'b01, 2'd0, 2'd3);
        chk("first_led_run1", led, 4'b0010);
        wait_drain("drain_run1");
        pulse_start(2'b01, 2'd0, 2'd3);
        chk("first_led_run2", led, 4'b0010);
        wait_drain("drain_run2");

        repeat (3) begin
            pulse_next();
            wait_drain("drain_round");
        end
        chk("len_round4", len_o, 4);
        check_rd("rd_round4");

        // Asynchronous reset between clock edges during ON
        mon_en = 1'b0;
        q.delete();
        raw_next();
        wait_led(1'b1, "led_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_active", active, 0);
        chk("async_rst_len", len_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Slowest speed, shortest target: 8 rounds then complete instead of another round
        pulse_start(2'b01, 2'd0, 2'd0);
        wait_drain("drain_slow1");
        repeat (7) begin
            pulse_next();
            wait_drain("drain_slow");
        end
        chk("len_target8", len_o, 8);
        d0 = done_seen;
        raw_next();
        q.push_back('{K_COMPLETE, 4'b0000, 0, -1});
        wait_drain("complete_pulse");
        repeat (10) @(negedge clk);
        chk("no_done_on_complete", done_seen, d0);
        chk("len_held_8", len_o, 8);
        check_rd("rd_slow");

        // Enable drop mid-playback
        pulse_start(2'b01, 2'd1, 2'd3);
        wait_drain("drain_abort1");
        mon_en = 1'b0;
        raw_next();
        wait_led(1'b1, "led_before_disable");
        d0 = done_seen;
        @(posedge clk); #1; enable = 1'b0;
        @(posedge clk); #1;
        chk("disable_led", led, 0);
        chk("disable_active", active, 0);
        chk("disable_len", len_o, 0);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("disable_no_done", done_seen, d0);
        chk("disable_stays_idle", active, 0);

        // Restart during OFF, then i_next during ON is ignored
        @(posedge clk); #1; mode = 2'b01; level = 2'd1; speed = 2'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_led(1'b1, "led_before_off");
        wait_led(1'b0, "off_reached");
        pulse_start(2'b01, 2'd1, 2'd3);
        wait_led(1'b1, "led_before_next_on");
        raw_next();
        wait_drain("drain_ignored_next");
        repeat (10) @(negedge clk);
        chk("next_in_on_len", len_o, 1);
        chk("next_in_on_idle", active, 0);

        // Full-length game, 32 entries
        pulse_start(2'b01, 2'd3, 2'd3);
        wait_drain("drain_long1");
        repeat (31) begin
            pulse_next();
            wait_drain("drain_long");
        end
        chk("len_32", len_o, 32);
        check_rd("rd_long");
`ifdef SEQ_NO_REPEAT_EN
        for (int i = 1; i < 32; i++) begin
            rd_idx = 5'(i - 1);
            #1;
            tmp_c = rd_color;
            rd_idx = 5'(i);
            #1;
            chk("no_repeat", (rd_color != tmp_c), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
